md_unit: RTL and testbench
==========================

# md_unit

Multiply/divide unit for the E stage of the 5-stage pipeline. It owns the HI/LO registers, runs MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency, and serves MTHI/MTLO/MFHI/MFLO. It drives `busy` upstream to the hazard control stage, which stalls D whenever an md-class instruction sits in D while `start | busy` is high.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  E-stage md operation valid this cycle; sampled on the rising edge.
- `md_op`  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 reserved, treated as NOP.
- `src_a`  in  32  rs value, already forwarded.
- `src_b`  in  32  rt value, already forwarded.
- `rd_sel`  in  1  0 selects LO, 1 selects HI for `rdata`.
- `busy`  out  1  operation in flight.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.
- `rdata`  out  32  combinational `rd_sel ? hi : lo` (MFHI/MFLO data).

## Operation
- States: IDLE and RUN. Reset puts the unit in IDLE with `busy=0`, `hi=0`, `lo=0`, counter=0 and pending results=0.
- Start of a long operation (IDLE, `start=1`, `md_op` in 1..4):
  - Latch the full result into `pend_hi`/`pend_lo`.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Move to RUN.
- Result rules:
  - MULT: signed 64-bit product, `{hi,lo}`.
  - MULTU: unsigned 64-bit product, `{hi,lo}`.
  - DIV: `lo` = signed quotient truncated toward zero; `hi` = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (`src_b==0`) on DIV or DIVU: the unit still goes busy for DIV_CYCLES, but HI/LO stay unchanged at completion (a pend-valid flag is cleared).
- DIV overflow (0x80000000 / -1): LO=0x80000000, HI=0.
- RUN: the counter decrements each cycle. On the cycle the counter equals 1, the next edge commits the pending result to HI/LO and returns to IDLE.
- MTHI/MTLO in IDLE: write `src_a` to HI or LO on the same edge. The unit does not go busy.
- `start` while in RUN: ignored. The hazard unit guarantees this never happens, and the bench checks it with an assertion.
- `rst_n` low mid-operation: aborts immediately to the reset state. No partial commit.

## Timing
- Edge t samples `start` for MULT. `busy` is 1 during cycles t+1 .. t+MULT_CYCLES.
- HI/LO hold the new value from cycle t+MULT_CYCLES+1, the same cycle `busy` falls.
- DIV follows the same pattern with DIV_CYCLES.
- The cycle in which `start=1` itself shows `busy=0`. The hazard unit must OR in its own `start` decode to stall in that cycle.
- MTHI/MTLO: the new value is visible in the cycle after the edge.
- `rdata` has zero latency from `hi`/`lo` and `rd_sel`.
- Back-to-back: a new `start` is accepted in the first cycle `busy=0` after completion.

## Structure
- Shared package `md_pkg` holds:
  - the `md_op` encodings (MD_NOP, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO);
  - the state encoding;
  - the latency defaults.
- One natural sub-module: `md_arith`. It is purely combinational: `md_op`, `src_a`, `src_b` in; 64-bit result and `div_zero` out. It keeps signed/unsigned and overflow rules out of the sequencer.

## Test plan
- MULT: `src_a=0xFFFFFFFE` (-2), `src_b=3`, start at edge t.
  - `busy` high for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MULTU with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- DIV: `src_a=-7` (0xFFFFFFF9), `src_b=2`.
  - `busy` high for exactly 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2 gives LO=3, HI=1.
- Divide by zero: preload HI=0x11, LO=0x22 via MTHI/MTLO, then DIV by 0.
  - Busy for 10 cycles.
  - HI/LO remain 0x11/0x22.
- MTLO `src_a=0xDEADBEEF` with `rd_sel=0`.
  - `rdata=0xDEADBEEF` the next cycle.
  - `busy` never asserts.
- Reset mid-operation: start MULT 5×5, then drop `rst_n` at cycle 2.
  - `busy`, HI and LO become 0 immediately.
  - After release, no commit of 25 occurs.
- Back-to-back: MULT, then DIV started in the first non-busy cycle.
  - DIV is accepted.
  - HI/LO hold the MULT result during the whole DIV busy window, then update to the DIV result.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the E-stage multiply/divide unit:
// operation encodings, sequencer states and default latencies.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_arith.sv
// Combinational arithmetic core: full 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU,
// with the signed, overflow and divide-by-zero rules kept out of the sequencer.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  md_op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    output logic [63:0] result_o,
    output logic        div_zero_o
);

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        b_zero;
    logic        div_ovf;

    assign ext_a   = {{32{src_a_i[31]}}, src_a_i};
    assign ext_b   = {{32{src_b_i[31]}}, src_b_i};
    assign mag_a   = src_a_i[31] ? (32'd0 - src_a_i) : src_a_i;
    assign mag_b   = src_b_i[31] ? (32'd0 - src_b_i) : src_b_i;
    assign b_zero  = (src_b_i == 32'd0);
    assign div_ovf = (src_a_i == 32'h8000_0000) && (src_b_i == 32'hFFFF_FFFF);

    // Signed divide works on magnitudes, then restores signs: quotient truncates toward zero, remainder follows the dividend.
    always_comb begin
        result_o   = 64'd0;
        div_zero_o = 1'b0;
        quo        = 32'd0;
        rem        = 32'd0;
        case (md_op_e'(md_op_i))
            MD_MULT:  result_o = ext_a * ext_b;
            MD_MULTU: result_o = {32'd0, src_a_i} * {32'd0, src_b_i};
            MD_DIV: begin
                div_zero_o = b_zero;
                if (div_ovf) begin
                    result_o = {32'd0, 32'h8000_0000};
                end else if (!b_zero) begin
                    quo      = mag_a / mag_b;
                    rem      = mag_a % mag_b;
                    result_o = {src_a_i[31] ? (32'd0 - rem) : rem,
                                (src_a_i[31] ^ src_b_i[31]) ? (32'd0 - quo) : quo};
                end
            end
            MD_DIVU: begin
                div_zero_o = b_zero;
                if (!b_zero) begin
                    result_o = {src_a_i % src_b_i, src_a_i / src_b_i};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, computes long operations up front and
// commits them after a fixed latency, and serves MTHI/MTLO/MFHI/MFLO.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    md_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_vld_q, pend_vld_d;
    logic [63:0] arith_result;
    logic        arith_div_zero;

    md_arith u_arith (
        .md_op_i    (md_op),
        .src_a_i    (src_a),
        .src_b_i    (src_b),
        .result_o   (arith_result),
        .div_zero_o (arith_div_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            pend_hi_q  <= 32'd0;
            pend_lo_q  <= 32'd0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            pend_hi_q  <= pend_hi_d;
            pend_lo_q  <= pend_lo_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    // The result is latched at start; RUN only counts down and commits it on the final edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        pend_hi_d  = pend_hi_q;
        pend_lo_d  = pend_lo_q;
        pend_vld_d = pend_vld_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (md_op_e'(md_op))
                        MD_MULT, MD_MULTU: begin
                            {pend_hi_d, pend_lo_d} = arith_result;
                            pend_vld_d = 1'b1;
                            cnt_d      = CW'(MULT_CYCLES);
                            state_d    = ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            {pend_hi_d, pend_lo_d} = arith_result;
                            pend_vld_d = !arith_div_zero;
                            cnt_d      = CW'(DIV_CYCLES);
                            state_d    = ST_RUN;
                        end
                        MD_MTHI: hi_d = src_a;
                        MD_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d    = ST_IDLE;
                    pend_vld_d = 1'b0;
                    if (pend_vld_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == ST_RUN);
        hi    = hi_q;
        lo    = lo_q;
        rdata = rd_sel ? hi_q : lo_q;
    end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: directed cases plus random operations checked
// against an arithmetic reference model of HI/LO.
module tb_md_unit;
    import md_pkg::*;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        rd_sel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] mdlHi = 32'd0;
    logic [31:0] mdlLo = 32'd0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] oldHi;
        logic [31:0] oldLo;
        int          cycles;
    } exp_t;

    exp_t sbq[$];
    int   runLen   = 0;
    logic prevBusy = 1'b0;

    md_unit #(.MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .md_op  (md_op),
        .src_a  (src_a),
        .src_b  (src_b),
        .rd_sel (rd_sel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .rdata  (rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) assert (!(busy && start)) else $error("[TB] start issued while busy");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got unexpected DUT activity, expected none", name);
    endtask

    // Architectural effect of one operation on {HI,LO}, straight from the ISA rules.
    function automatic logic [63:0] refModel(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] curHi,
                                             input logic [31:0] curLo);
        logic [63:0] r;
        int          sa;
        int          sb;
        r  = {curHi, curLo};
        sa = signed'(a);
        sb = signed'(b);
        case (op)
            3'd1: r = longint'(sa) * longint'(sb);
            3'd2: r = {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b != 32'd0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                    else begin
                        r[31:0]  = 32'(sa / sb);
                        r[63:32] = 32'(sa % sb);
                    end
                end
            end
            3'd4: if (b != 32'd0) r = {a % b, a / b};
            3'd5: r[63:32] = a;
            3'd6: r[31:0]  = a;
            default: ;
        endcase
        return r;
    endfunction

    // Caller sits just after a rising edge with the unit idle; returns just after the sampling edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        exp_t        e;
        r = refModel(op, a, b, mdlHi, mdlLo);
        if (op >= 3'd1 && op <= 3'd4) begin
            e.oldHi  = mdlHi;
            e.oldLo  = mdlLo;
            e.hi     = r[63:32];
            e.lo     = r[31:0];
            e.cycles = (op <= 3'd2) ? MULT_LAT : DIV_LAT;
            sbq.push_back(e);
        end
        mdlHi = r[63:32];
        mdlLo = r[31:0];
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        md_op = 3'd0;
        src_a = $urandom;
        src_b = $urandom;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) reportFail("busy_timeout");
    endtask

    task automatic checkArch();
        checkOutput("arch_hi", hi, mdlHi);
        checkOutput("arch_lo", lo, mdlLo);
        checkOutput("arch_busy", {31'd0, busy}, 32'd0);
        rd_sel = 1'($urandom_range(0, 1));
        #1;
        checkOutput("arch_rdata", rdata, rd_sel ? mdlHi : mdlLo);
    endtask

    // Monitor: tracks each busy window and retires one scoreboard entry when it closes.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
            runLen   = 0;
            prevBusy = 1'b0;
        end else begin
            if (busy) begin
                runLen++;
                if (sbq.size() == 0) reportFail("busy_unexpected");
                else begin
                    checkOutput("hold_hi", hi, sbq[0].oldHi);
                    checkOutput("hold_lo", lo, sbq[0].oldLo);
                end
            end else if (prevBusy) begin
                if (sbq.size() == 0) reportFail("done_without_op");
                else begin
                    e = sbq.pop_front();
                    checkOutput("busy_len", 32'(runLen), 32'(e.cycles));
                    checkOutput("res_hi", hi, e.hi);
                    checkOutput("res_lo", lo, e.lo);
                end
                runLen = 0;
            end
            prevBusy = busy;
        end
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        rst_n  = 1'b0;
        start  = 1'b0;
        md_op  = 3'd0;
        src_a  = 32'd0;
        src_b  = 32'd0;
        rd_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        waitIdle();
        checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo, 32'hFFFF_FFFA);
        applyStimulus(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
        waitIdle();
        checkOutput("multu_hi", hi, 32'h0000_0002);
        checkOutput("multu_lo", lo, 32'hFFFF_FFFA);
        applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        waitIdle();
        checkOutput("div_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_hi", hi, 32'hFFFF_FFFF);
        applyStimulus(MD_DIVU, 32'd7, 32'd2);
        waitIdle();
        checkOutput("divu_lo", lo, 32'd3);
        checkOutput("divu_hi", hi, 32'd1);

        applyStimulus(MD_MTHI, 32'h11, 32'd0);
        applyStimulus(MD_MTLO, 32'h22, 32'd0);
        applyStimulus(MD_DIV, 32'd5, 32'd0);
        waitIdle();
        checkOutput("div0_hi", hi, 32'h11);
        checkOutput("div0_lo", lo, 32'h22);

        applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        waitIdle();
        checkOutput("ovf_lo", lo, 32'h8000_0000);
        checkOutput("ovf_hi", hi, 32'd0);

        rd_sel = 1'b0;
        applyStimulus(MD_MTLO, 32'hDEAD_BEEF, 32'd0);
        checkOutput("mtlo_rdata", rdata, 32'hDEAD_BEEF);
        checkOutput("mtlo_busy", {31'd0, busy}, 32'd0);
        checkArch();

        applyStimulus(MD_MULT, 32'd6, 32'd7);
        waitIdle();
        applyStimulus(MD_DIV, 32'd100, 32'd7);
        waitIdle();
        checkOutput("b2b_lo", lo, 32'd14);
        checkOutput("b2b_hi", hi, 32'd2);

        applyStimulus(MD_MULT, 32'd5, 32'd5);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_hi", hi, 32'd0);
        checkOutput("abort_lo", lo, 32'd0);
        mdlHi = 32'd0;
        mdlLo = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("no_commit_lo", lo, 32'd0);
        checkOutput("no_commit_hi", hi, 32'd0);
        checkOutput("no_commit_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            applyStimulus(op, a, b);
            waitIdle();
            checkArch();
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_drain", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
